// File: rtl/lfsr_gen.sv
// Run-time configurable LFSR engine: Fibonacci/Galois stepping, seed load,
// serial injection, all-zero lock-up recovery and period measurement.
module lfsr_gen #(
   parameter int WIDTH = 8,
   parameter logic [WIDTH-1:0] RESET_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mode,
   input  logic [WIDTH-1:0] taps,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   input  logic             inj_en,
   input  logic             d,
   output logic [WIDTH-1:0] state,
   output logic             out_bit,
   output logic             lockup,
   output logic             period_done,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] step_cnt
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] seed_reg;
   logic             inj_bit;
   logic             fib_fb;
   logic [WIDTH-1:0] fib_next;
   logic [WIDTH-1:0] gal_next;
   logic [WIDTH-1:0] step_next;
   logic [WIDTH-1:0] cnt_inc;
   logic [WIDTH-1:0] recover_val;

   assign out_bit = state[WIDTH-1];

   // Both step flavours are computed every cycle; mode picks one at the step.
   always_comb begin
      inj_bit     = inj_en & d;
      fib_fb      = (^(state & taps)) ^ inj_bit;
      fib_next    = {state[WIDTH-2:0], fib_fb};
      gal_next    = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? taps : '0)
                    ^ {{(WIDTH-1){1'b0}}, inj_bit};
      step_next   = mode ? gal_next : fib_next;
      cnt_inc     = (&step_cnt) ? step_cnt : step_cnt + ONE;
      recover_val = (seed_reg == '0) ? ONE : seed_reg;
   end

   // Priority: load, then lock-up recovery, then a normal step, else hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RESET_SEED;
         seed_reg    <= RESET_SEED;
         step_cnt    <= '0;
         period      <= '0;
         lockup      <= 1'b0;
         period_done <= 1'b0;
      end else begin
         lockup      <= 1'b0;
         period_done <= 1'b0;
         if (load) begin
            state    <= seed;
            seed_reg <= seed;
            step_cnt <= '0;
         end else if (en) begin
            if (state == '0) begin
               state  <= recover_val;
               lockup <= 1'b1;
            end else begin
               state <= step_next;
               if (step_next == seed_reg) begin
                  period_done <= 1'b1;
                  period      <= cnt_inc;
                  step_cnt    <= '0;
               end else begin
                  step_cnt <= cnt_inc;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: directed scenarios plus a randomized run,
// all compared against an arithmetic reference model of the LFSR rules.
module tb_lfsr_gen;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       mode;
   logic [7:0] taps;
   logic       load;
   logic [7:0] seed;
   logic       inj_en;
   logic       d;
   logic [7:0] state;
   logic       out_bit;
   logic       lockup;
   logic       period_done;
   logic [7:0] period;
   logic [7:0] step_cnt;

   int checkCount = 0;
   int passCount  = 0;

   int mState, mSeed, mCnt, mPeriod, mLock, mDone;

   lfsr_gen #(.WIDTH(8), .RESET_SEED(8'h01)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .taps(taps),
      .load(load), .seed(seed), .inj_en(inj_en), .d(d),
      .state(state), .out_bit(out_bit), .lockup(lockup),
      .period_done(period_done), .period(period), .step_cnt(step_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input int observed, input int expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   task automatic modelReset();
      mState = 1; mSeed = 1; mCnt = 0; mPeriod = 0; mLock = 0; mDone = 0;
   endtask

   // The reference works from the rules in plain integer arithmetic.
   task automatic modelStep(input int ld, input int e, input int md, input int tp,
                            input int sd, input int inj, input int db);
      int nxt;
      mLock = 0;
      mDone = 0;
      if (ld != 0) begin
         mState = sd; mSeed = sd; mCnt = 0;
      end else if (e != 0 && mState == 0) begin
         mState = (mSeed == 0) ? 1 : mSeed;
         mLock = 1;
      end else if (e != 0) begin
         if (md == 0)
            nxt = ((mState * 2) % 256) + (($countones(mState & tp) + (inj & db)) % 2);
         else
            nxt = ((mState * 2) % 256) ^ ((mState >= 128) ? tp : 0) ^ (inj & db);
         mCnt = (mCnt + 1 > 255) ? 255 : mCnt + 1;
         if (nxt == mSeed) begin
            mDone = 1; mPeriod = mCnt; mCnt = 0;
         end
         mState = nxt;
      end
   endtask

   task automatic applyStimulus(input logic ld, input logic e, input logic md,
                                input logic [7:0] tp, input logic [7:0] sd,
                                input logic inj, input logic db);
      load = ld; en = e; mode = md; taps = tp; seed = sd; inj_en = inj; d = db;
      @(posedge clk);
      modelStep(int'(ld), int'(e), int'(md), int'(tp), int'(sd), int'(inj), int'(db));
      #1;
   endtask

   task automatic checkOutput(input string tag);
      checkVal({tag, ".state"}, int'(state), mState);
      checkVal({tag, ".out_bit"}, int'(out_bit), (mState >> 7) & 1);
      checkVal({tag, ".lockup"}, int'(lockup), mLock);
      checkVal({tag, ".period_done"}, int'(period_done), mDone);
      checkVal({tag, ".period"}, int'(period), mPeriod);
      checkVal({tag, ".step_cnt"}, int'(step_cnt), mCnt);
   endtask

   initial begin
      int donePulses;
      int doneStep;
      int expSeq[8];
      logic [7:0] rTaps;
      logic       rMode;

      rst_n = 1'b0; en = 0; load = 0; mode = 0; taps = 8'h00; seed = 8'h00;
      inj_en = 0; d = 0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset");
      checkVal("reset.state_const", int'(state), 8'h01);
      @(negedge clk);
      rst_n = 1'b1;

      // Fibonacci sequence from seed 0x01 with taps 0xB8
      applyStimulus(1, 0, 0, 8'hB8, 8'h01, 0, 0);
      checkOutput("fib_load");
      expSeq[0] = 8'h02; expSeq[1] = 8'h04; expSeq[2] = 8'h08;
      expSeq[3] = 8'h11; expSeq[4] = 8'h23;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 1, 0, 8'hB8, 8'h01, 0, 0);
         checkOutput("fib_seq");
         checkVal("fib_seq_const", int'(state), expSeq[i]);
      end
      checkVal("fib_step_cnt5", int'(step_cnt), 5);

      // Galois sequence from seed 0x01 with taps 0x1D
      applyStimulus(1, 0, 1, 8'h1D, 8'h01, 0, 0);
      expSeq[0] = 8'h02; expSeq[1] = 8'h04; expSeq[2] = 8'h08; expSeq[3] = 8'h10;
      expSeq[4] = 8'h20; expSeq[5] = 8'h40; expSeq[6] = 8'h80; expSeq[7] = 8'h1D;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 1, 1, 8'h1D, 8'h01, 0, 0);
         checkOutput("gal_seq");
         checkVal("gal_seq_const", int'(state), expSeq[i]);
      end

      // Full-period measurement in both modes
      for (int m = 0; m < 2; m++) begin
         applyStimulus(1, 0, m[0], (m == 0) ? 8'hB8 : 8'h1D, 8'h01, 0, 0);
         donePulses = 0;
         doneStep = 0;
         for (int i = 1; i <= 255; i++) begin
            applyStimulus(0, 1, m[0], (m == 0) ? 8'hB8 : 8'h1D, 8'h01, 0, 0);
            checkOutput("period_run");
            if (period_done) begin
               donePulses++;
               doneStep = i;
            end
         end
         checkVal("period_pulses", donePulses, 1);
         checkVal("period_step", doneStep, 255);
         checkVal("period_val", int'(period), 255);
         checkVal("period_cnt0", int'(step_cnt), 0);
      end

      // Lock-up recovery with a zero seed
      applyStimulus(1, 0, 0, 8'hB8, 8'h00, 0, 0);
      checkOutput("lock_load0");
      applyStimulus(0, 1, 0, 8'hB8, 8'h00, 0, 0);
      checkOutput("lock_recover");
      checkVal("lock_pulse", int'(lockup), 1);
      checkVal("lock_state", int'(state), 8'h01);
      applyStimulus(1, 0, 0, 8'hB8, 8'h5A, 0, 0);
      applyStimulus(1, 0, 0, 8'hB8, 8'h00, 0, 0);
      applyStimulus(0, 1, 0, 8'hB8, 8'h00, 0, 0);
      checkOutput("lock_seedreg0");
      checkVal("lock_seedreg0_state", int'(state), 8'h01);
      applyStimulus(0, 1, 0, 8'hB8, 8'h00, 0, 0);
      checkOutput("lock_after");

      // load wins over en, then hold with en=0
      applyStimulus(1, 1, 0, 8'hB8, 8'h3C, 0, 0);
      checkOutput("load_en");
      checkVal("load_en_state", int'(state), 8'h3C);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 8'hB8, 8'h00, 0, 0);
         checkOutput("hold");
      end
      checkVal("hold_state", int'(state), 8'h3C);
      checkVal("hold_cnt", int'(step_cnt), 0);

      // Step counter saturation on a sequence that never revisits its seed
      applyStimulus(1, 0, 0, 8'h01, 8'h03, 0, 0);
      for (int i = 0; i < 300; i++) begin
         applyStimulus(0, 1, 0, 8'h01, 8'h03, 0, 0);
         if (i % 50 == 0 || i > 250) checkOutput("sat_run");
      end
      checkVal("sat_cnt", int'(step_cnt), 8'hFF);
      checkVal("sat_state", int'(state), 8'hFF);

      // Injection, then asynchronous reset mid-run
      applyStimulus(1, 0, 0, 8'hB8, 8'h01, 0, 0);
      applyStimulus(0, 1, 0, 8'hB8, 8'h01, 1, 1);
      checkOutput("inj");
      checkVal("inj_state", int'(state), 8'h03);
      applyStimulus(0, 1, 0, 8'hB8, 8'h01, 1, 0);
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("async_rst");
      checkVal("async_rst_state", int'(state), 8'h01);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 1, 0, 8'hB8, 8'h00, 0, 0);
      checkOutput("post_rst_step");
      checkVal("post_rst_state", int'(state), 8'h02);

      // Randomized run against the reference model
      rTaps = 8'hB8;
      rMode = 1'b0;
      for (int i = 0; i < 400; i++) begin
         logic rLoad;
         logic [7:0] rSeed;
         if ($urandom_range(0, 19) == 0) rTaps = 8'($urandom);
         if ($urandom_range(0, 9) == 0) rMode = 1'($urandom);
         rLoad = ($urandom_range(0, 15) == 0);
         rSeed = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         applyStimulus(rLoad, ($urandom_range(0, 3) != 0), rMode, rTaps, rSeed,
                       ($urandom_range(0, 3) == 0), 1'($urandom));
         checkOutput("random");
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
Parametrised, run-time configurable LFSR engine; the successor to the fixed-length simple LFSR. It supports Fibonacci and Galois modes, a run-time tap mask, seed loading, optional serial data injection, lock-up recovery and hardware period measurement. It sits in the LFSR library as the common source for PRBS generation, scrambling and sequence-length experiments.

Parameters:
WIDTH, 8, register length in bits; legal range 3..32.
RESET_SEED, 1, state and seed value applied on reset; must be non-zero.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  advance the register by one step this cycle
mode  input  1  0 = Fibonacci, 1 = Galois; sampled on every step
taps  input  WIDTH  feedback tap mask; must be held stable while en=1
load  input  1  load seed into state this cycle
seed  input  WIDTH  value loaded when load=1
inj_en  input  1  enable serial injection into the feedback bit
d  input  1  serial injection bit, XORed into feedback when inj_en=1
state  output  WIDTH  current register contents
out_bit  output  1  serial output, equal to state[WIDTH-1]
lockup  output  1  one-cycle pulse: all-zero state was recovered
period_done  output  1  one-cycle pulse: state has returned to the stored seed
period  output  WIDTH  step count of the last completed cycle
step_cnt  output  WIDTH  steps taken since the last load or reset; saturates at all-ones

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = RESET_SEED; seed_reg = RESET_SEED.
  - step_cnt = 0; period = 0; lockup = 0; period_done = 0.
- All outputs are registered except out_bit, which is a direct wire from state.
- Priority each cycle: load > lock-up recovery > step > hold.
- load=1:
  - state <= seed; seed_reg <= seed; step_cnt <= 0.
  - No step occurs, even if en=1. Pulses are 0.
  - A seed of 0 is accepted.
- Lock-up recovery: condition is en=1, load=0 and state==0.
  - state <= seed_reg, or 1 if seed_reg==0.
  - lockup=1 for that cycle; step_cnt is unchanged; no period check.
- Fibonacci step (en=1, mode=0, state!=0):
  - fb = XOR-reduce(state & taps) ^ (inj_en & d).
  - state <= {state[WIDTH-2:0], fb}.
- Galois step (en=1, mode=1, state!=0):
  - t = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? taps : 0).
  - state <= t ^ {{WIDTH-1{0}}, inj_en & d}.
- Step counter and period check, on every step:
  - step_cnt <= step_cnt+1, saturating at all-ones.
  - If the next state == seed_reg: period_done=1, period <= step_cnt+1, step_cnt <= 0.
- The period check also fires with inj_en=1; it is meaningful only with inj_en=0.
- en=0 and load=0: all registers hold and pulses are 0.
- Changing mode or taps between steps is legal and takes effect on the next step; step_cnt is not cleared.
- Reset asserted mid-sequence returns all registers to reset values immediately; the first step after release uses RESET_SEED.

Test Plan:
- Reset, then load seed=0x01, mode=0, taps=0xB8, en=1, inj_en=0 -> state sequence 02,04,08,11,23; out_bit tracks state[7]; step_cnt=5 after 5 steps.
- Load 0x01, mode=1, taps=0x1D, en=1 -> 02,04,08,10,20,40,80,1D.
- Load 0x01, taps=0xB8 (Fibonacci), run 255 steps -> period_done pulses exactly on step 255, period=255, step_cnt=0. Repeat in Galois mode with taps=0x1D -> period=255.
- Load seed=0x00 then en=1 -> lockup pulses on the first en cycle and state=0x01. Load 0x5A, force the state to 0 via load 0, en=1 -> state=0x01 because seed_reg=0.
- load=1 and en=1 in the same cycle with seed=0x3C -> state=0x3C with no step; en=0 for 3 cycles -> state stays 0x3C and step_cnt=0.
- Fibonacci, seed 0x01, taps 0xB8, inj_en=1, d=1 -> first step gives 0x03. Assert rst_n=0 mid-run -> state=RESET_SEED immediately, before the next clock edge.
